// File: rtl/adc_acq_regs_pkg.sv
// Shared register map, bit positions and helpers for the ADC acquisition AXI4-Lite slave.
package adc_acq_regs_pkg;

  localparam logic [4:0] ADDR_CTRL     = 5'h00;
  localparam logic [4:0] ADDR_DDR_BASE = 5'h04;
  localparam logic [4:0] ADDR_LEN      = 5'h08;
  localparam logic [4:0] ADDR_SCRATCH  = 5'h0C;
  localparam logic [4:0] ADDR_STATUS   = 5'h10;
  localparam logic [4:0] ADDR_COUNT    = 5'h14;

  localparam logic [2:0] IDX_CTRL     = ADDR_CTRL[4:2];
  localparam logic [2:0] IDX_DDR_BASE = ADDR_DDR_BASE[4:2];
  localparam logic [2:0] IDX_LEN      = ADDR_LEN[4:2];
  localparam logic [2:0] IDX_SCRATCH  = ADDR_SCRATCH[4:2];
  localparam logic [2:0] IDX_STATUS   = ADDR_STATUS[4:2];
  localparam logic [2:0] IDX_COUNT    = ADDR_COUNT[4:2];

  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [0:0] {StIdle, StResp} wr_state_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/adc_acq_axil_wr_ch.sv
// AXI4-Lite write-channel handshake: joint AW/W acceptance and BVALID hold until BREADY.
module adc_acq_axil_wr_ch
  import adc_acq_regs_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic awvalid_i,
  input  logic wvalid_i,
  input  logic bready_i,
  output logic awready_o,
  output logic wready_o,
  output logic bvalid_o,
  output logic wr_en_o
);

  wr_state_e state_q;
  logic      awready_q;
  logic      bvalid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (awready_q) begin
            awready_q <= 1'b0;
            if (awvalid_i && wvalid_i) begin
              bvalid_q <= 1'b1;
              state_q  <= StResp;
            end
          end else if (awvalid_i && wvalid_i) begin
            awready_q <= 1'b1;
          end
        end
        StResp: begin
          if (bready_i) begin
            bvalid_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign awready_o = awready_q;
  assign wready_o  = awready_q;
  assign bvalid_o  = bvalid_q;
  // Register file commits on the edge that closes the AW/W handshake.
  assign wr_en_o   = awready_q & awvalid_i & wvalid_i;

endmodule

// File: rtl/adc_acq_axil_regs.sv
// AXI4-Lite register file for the ADC-to-DDR acquisition core: control, DMA setup, status.
module adc_acq_axil_regs
  import adc_acq_regs_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            acq_busy,
  input  logic                            acq_done,
  input  logic [31:0]                     acq_count,
  output logic                            acq_start,
  output logic [31:0]                     ddr_base,
  output logic [31:0]                     acq_len
);

  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [31:0] ctrl_q, ctrl_d, base_q, base_d, len_q, len_d, scratch_q, scratch_d;
  logic        done_q, done_d, start_q, start_d, w1c;
  logic        arready_q, arready_d, rvalid_q, rvalid_d, rd_fire;
  logic [31:0] rdata_q, rdata_d, rd_mux;
  logic        unused_inputs;

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  adc_acq_axil_wr_ch u_wr_ch (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .awvalid_i (S_AXI_AWVALID),
    .wvalid_i  (S_AXI_WVALID),
    .bready_i  (S_AXI_BREADY),
    .awready_o (S_AXI_AWREADY),
    .wready_o  (S_AXI_WREADY),
    .bvalid_o  (S_AXI_BVALID),
    .wr_en_o   (wr_en)
  );

  assign wr_idx = S_AXI_AWADDR[4:2];

  always_comb begin
    ctrl_d    = ctrl_q;
    base_d    = base_q;
    len_d     = len_q;
    scratch_d = scratch_q;
    start_d   = 1'b0;
    w1c       = 1'b0;
    if (wr_en) begin
      case (wr_idx)
        IDX_CTRL: begin
          ctrl_d                 = apply_wstrb(ctrl_q, S_AXI_WDATA, S_AXI_WSTRB);
          ctrl_d[CTRL_START_BIT] = 1'b0;
          start_d                = S_AXI_WSTRB[0] & S_AXI_WDATA[CTRL_START_BIT];
        end
        IDX_DDR_BASE: base_d    = apply_wstrb(base_q, S_AXI_WDATA, S_AXI_WSTRB);
        IDX_LEN:      len_d     = apply_wstrb(len_q, S_AXI_WDATA, S_AXI_WSTRB);
        IDX_SCRATCH:  scratch_d = apply_wstrb(scratch_q, S_AXI_WDATA, S_AXI_WSTRB);
        IDX_STATUS:   w1c       = S_AXI_WSTRB[0] & S_AXI_WDATA[STATUS_DONE_BIT];
        default: ;
      endcase
    end
    // A done pulse in the same cycle as the W1C keeps the flag set.
    done_d = acq_done | (done_q & ~w1c);
  end

  always_comb begin
    rd_mux = '0;
    case (S_AXI_ARADDR[4:2])
      IDX_CTRL:     rd_mux = ctrl_q;
      IDX_DDR_BASE: rd_mux = base_q;
      IDX_LEN:      rd_mux = len_q;
      IDX_SCRATCH:  rd_mux = scratch_q;
      IDX_STATUS: begin
        rd_mux[STATUS_BUSY_BIT] = acq_busy;
        rd_mux[STATUS_DONE_BIT] = done_q;
      end
      IDX_COUNT:    rd_mux = acq_count;
      default: ;
    endcase
  end

  always_comb begin
    rd_fire   = arready_q & S_AXI_ARVALID;
    arready_d = S_AXI_ARVALID & ~rvalid_q & ~arready_q;
    rdata_d   = rd_fire ? rd_mux : rdata_q;
    rvalid_d  = rvalid_q;
    if (rd_fire) begin
      rvalid_d = 1'b1;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ctrl_q    <= '0;
      base_q    <= '0;
      len_q     <= '0;
      scratch_q <= '0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      base_q    <= base_d;
      len_q     <= len_d;
      scratch_q <= scratch_d;
      done_q    <= done_d;
      start_q   <= start_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign acq_start     = start_q;
  assign ddr_base      = base_q;
  assign acq_len       = len_q;

endmodule

// File: tb/tb_adc_acq_axil_regs.sv
// Self-checking bench for adc_acq_axil_regs: vector table, corner sequences, random vs model.
module tb_adc_acq_axil_regs;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [4:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [4:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic        acq_busy = 1'b0;
  logic        acq_done = 1'b0;
  logic [31:0] acq_count = '0;
  logic        acq_start;
  logic [31:0] ddr_base;
  logic [31:0] acq_len;

  adc_acq_axil_regs dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .acq_busy      (acq_busy),
    .acq_done      (acq_done),
    .acq_count     (acq_count),
    .acq_start     (acq_start),
    .ddr_base      (ddr_base),
    .acq_len       (acq_len)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;

  // Reference model: the four RW words, sticky done flag.
  logic [31:0] mdl [4];
  logic        mdl_done;

  always @(negedge ACLK) if (acq_start === 1'b1) start_cnt++;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    int          exp_start;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic sig_of(input int w);
    case (w)
      0:       return S_AXI_AWREADY;
      1:       return S_AXI_BVALID;
      2:       return S_AXI_ARREADY;
      default: return S_AXI_RVALID;
    endcase
  endfunction

  task automatic wait_for(input int w, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge ACLK);
      seen = (sig_of(w) === 1'b1);
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s: got 0 for 50 cycles, expected 1", name);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] addr);
    logic [2:0] idx = addr[4:2];
    if (idx < 3'd4) return mdl[idx];
    if (idx == 3'd4) return {30'b0, mdl_done, acq_busy};
    if (idx == 3'd5) return acq_count;
    return 32'h0;
  endfunction

  task automatic model_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit done_hs, output int exp_start);
    logic [2:0] idx = addr[4:2];
    exp_start = 0;
    if (idx < 3'd4) begin
      for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
      if (idx == 3'd0) begin
        exp_start = (strb[0] && data[0]) ? 1 : 0;
        mdl[0][0] = 1'b0;
      end
    end else if (idx == 3'd4 && strb[0] && data[1]) begin
      mdl_done = 1'b0;
    end
    if (done_hs) mdl_done = 1'b1;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit done_hs);
    @(posedge ACLK); #1;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    wait_for(0, "awready");
    check("wready_with_awready", {31'b0, S_AXI_WREADY}, 32'h1);
    acq_done = done_hs;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; acq_done = 1'b0; S_AXI_BREADY = 1'b1;
    wait_for(1, "bvalid");
    check("bresp_okay", {30'b0, S_AXI_BRESP}, 32'h0);
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
  endtask

  // Write, update the model, and report how many start pulses followed.
  task automatic do_write(input logic [4:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input bit done_hs, output int pulses,
                          output int exp_start);
    int s0 = start_cnt;
    model_write(addr, data, strb, done_hs, exp_start);
    axi_write(addr, data, strb, done_hs);
    repeat (2) @(negedge ACLK);
    pulses = start_cnt - s0;
    check("ddr_base_out", ddr_base, mdl[1]);
    check("acq_len_out", acq_len, mdl[2]);
  endtask

  task automatic do_read(input logic [4:0] addr, output logic [31:0] data);
    @(posedge ACLK); #1;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    wait_for(2, "arready");
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
    wait_for(3, "rvalid");
    data = S_AXI_RDATA;
    check("rresp_okay", {30'b0, S_AXI_RRESP}, 32'h0);
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    int          p, ep;
    bit          seen, bv;

    for (int i = 0; i < 4; i++) mdl[i] = '0;
    mdl_done = 1'b0;

    vecs[0]  = '{5'h00, 32'h0000_0001, 4'hF, 32'h0000_0000, 1};
    vecs[1]  = '{5'h04, 32'h0000_0002, 4'hF, 32'h0000_0002, 0};
    vecs[2]  = '{5'h08, 32'h0000_0003, 4'hF, 32'h0000_0003, 0};
    vecs[3]  = '{5'h0C, 32'h0000_0004, 4'hF, 32'h0000_0004, 0};
    vecs[4]  = '{5'h0C, 32'h0000_0000, 4'hF, 32'h0000_0000, 0};
    vecs[5]  = '{5'h0C, 32'hAABB_CCDD, 4'h5, 32'h00BB_00DD, 0};
    vecs[6]  = '{5'h0C, 32'h1122_3344, 4'h0, 32'h00BB_00DD, 0};
    vecs[7]  = '{5'h18, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 0};
    vecs[8]  = '{5'h03, 32'hFFFF_FFFE, 4'hF, 32'hFFFF_FFFE, 0};
    vecs[9]  = '{5'h00, 32'h0000_0003, 4'h1, 32'hFFFF_FF02, 1};
    vecs[10] = '{5'h14, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 0};

    #12;
    check("rst_awready", {31'b0, S_AXI_AWREADY}, 32'h0);
    check("rst_bvalid", {31'b0, S_AXI_BVALID}, 32'h0);
    check("rst_arready", {31'b0, S_AXI_ARREADY}, 32'h0);
    check("rst_rvalid", {31'b0, S_AXI_RVALID}, 32'h0);
    check("rst_rdata", S_AXI_RDATA, 32'h0);
    check("rst_start", {31'b0, acq_start}, 32'h0);
    check("rst_ddr_base", ddr_base, 32'h0);
    @(negedge ACLK);
    ARESET = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 1'b0, p, ep);
      check($sformatf("vec%0d_start_pulses", i), p, vecs[i].exp_start);
      do_read(vecs[i].addr, rd);
      check($sformatf("vec%0d_readback", i), rd, vecs[i].exp_rd);
    end

    // AW leads W by 3 cycles; second write queued behind a 5-cycle B stall.
    @(posedge ACLK); #1;
    S_AXI_AWADDR = 5'h08; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF; S_AXI_AWVALID = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge ACLK);
      seen |= (S_AXI_AWREADY | S_AXI_WREADY);
    end
    check("no_ready_before_wvalid", {31'b0, seen}, 32'h0);
    @(posedge ACLK); #1;
    S_AXI_WVALID = 1'b1;
    wait_for(0, "awready_late_w");
    @(posedge ACLK); #1;
    S_AXI_WDATA = 32'h66;
    seen = 1'b0;
    bv = 1'b1;
    repeat (5) begin
      @(negedge ACLK);
      bv &= S_AXI_BVALID;
      seen |= S_AXI_AWREADY;
    end
    check("bvalid_held_5", {31'b0, bv}, 32'h1);
    check("no_accept_during_b", {31'b0, seen}, 32'h0);
    check("first_write_len", acq_len, 32'h55);
    S_AXI_BREADY = 1'b1;
    wait_for(0, "awready_second");
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    wait_for(1, "bvalid_second");
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    mdl[2] = 32'h66;
    do_read(5'h08, rd);
    check("second_write_len", rd, 32'h66);

    // Sticky done and W1C, including same-cycle set.
    @(posedge ACLK); #1; acq_done = 1'b1;
    @(posedge ACLK); #1; acq_done = 1'b0;
    mdl_done = 1'b1;
    do_read(5'h10, rd);
    check("done_sticky", rd, 32'h2);
    do_write(5'h10, 32'h2, 4'hF, 1'b0, p, ep);
    do_read(5'h10, rd);
    check("done_w1c", rd, 32'h0);
    do_write(5'h10, 32'h2, 4'hF, 1'b1, p, ep);
    do_read(5'h10, rd);
    check("done_set_wins", rd, 32'h2);
    do_write(5'h10, 32'h2, 4'hF, 1'b0, p, ep);

    acq_count = 32'h1234; acq_busy = 1'b1;
    do_read(5'h14, rd);
    check("count_live", rd, 32'h1234);
    do_read(5'h10, rd);
    check("busy_live", rd, 32'h1);
    do_write(5'h14, 32'hFFFF_FFFF, 4'hF, 1'b0, p, ep);
    do_read(5'h14, rd);
    check("count_ro", rd, 32'h1234);
    do_write(5'h00, 32'h1, 4'hF, 1'b0, p, ep);
    check("start_while_busy", p, 1);

    for (int n = 0; n < 60; n++) begin
      acq_busy = 1'($urandom_range(0, 1));
      acq_count = $urandom;
      a = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) begin
        @(posedge ACLK); #1; acq_done = 1'b1;
        @(posedge ACLK); #1; acq_done = 1'b0;
        mdl_done = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, ($urandom_range(0, 5) == 0), p, ep);
        check($sformatf("rand%0d_start_pulses", n), p, ep);
      end else begin
        do_read(a, rd);
        check($sformatf("rand%0d_read_%02h", n, a), rd, exp_read(a));
      end
    end

    // Reset while a read response is pending.
    do_write(5'h04, 32'hDEAD_0000, 4'hF, 1'b0, p, ep);
    @(posedge ACLK); #1;
    S_AXI_ARADDR = 5'h04; S_AXI_ARVALID = 1'b1;
    wait_for(2, "arready_rst");
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    wait_for(3, "rvalid_rst");
    #2 ARESET = 1'b1;
    #1;
    check("rst_async_rvalid", {31'b0, S_AXI_RVALID}, 32'h0);
    check("rst_async_ddr_base", ddr_base, 32'h0);
    @(negedge ACLK);
    ARESET = 1'b0;
    acq_busy = 1'b0;
    acq_count = '0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    mdl_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      do_read(5'(i * 4), rd);
      check($sformatf("post_rst_reg%0d", i), rd, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_acq_axil_regs.md
Name: adc_acq_axil_regs

Overview:
- AXI4-Lite slave register file that answers the S00_AXI master port of the ADC-to-DDR acquisition IP.
- Holds the acquisition control, DDR base address, transfer length and scratch registers.
- Exposes read-only status and sample-count registers fed from the acquisition core.
- Issues a one-cycle start pulse to the core. Sits between the PS GP master (AXI interconnect) and the acquisition/DMA logic.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word registers.

Ports:
- ACLK  in  1  system clock; all logic is on this single clock.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  5  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  5  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- acq_busy  in  1  acquisition core busy.
- acq_done  in  1  single-cycle done pulse from the core.
- acq_count  in  32  samples written to DDR so far.
- acq_start  out  1  single-cycle start pulse.
- ddr_base  out  32  REG1 value.
- acq_len  out  32  REG2 value.

Behaviour:
- Reset: all registers are 0. AWREADY, WREADY, BVALID, ARREADY, RVALID and acq_start are 0. BRESP, RRESP and RDATA are 0.
- Register map (word index = addr[4:2]; addr[1:0] are ignored):
  - 0x00 CTRL: RW. bit0 START self-clears and reads 0. bit1 IRQ_EN. bits[31:2] are RW scratch.
  - 0x04 DDR_BASE: RW.
  - 0x08 LEN: RW.
  - 0x0C SCRATCH: RW.
  - 0x10 STATUS: RO. bit0 = acq_busy (live). bit1 = DONE sticky; set by acq_done, cleared by writing 1 to bit1 at 0x10 (W1C). All other bits read 0.
  - 0x14 COUNT: RO, live acq_count.
  - 0x18, 0x1C: read 0; writes are ignored.
- All accesses respond OKAY (2'b00). The block never returns SLVERR or DECERR.
- Write channel:
  - AWREADY and WREADY pulse high together for exactly one cycle when AWVALID && WVALID && !BVALID && !(AWREADY).
  - AW and W arriving in different cycles wait until both are valid; there is no single-channel acceptance.
  - The register update occurs on the handshake edge. Per-byte WSTRB is honoured; a strobe of 0 leaves the register unchanged.
  - BVALID rises the cycle after the handshake and holds until BREADY. No new write is accepted while BVALID=1.
- START:
  - A write to 0x00 with WSTRB[0]=1 and WDATA[0]=1 drives acq_start=1 for exactly the cycle after the handshake.
  - The stored bit0 stays 0.
  - START while acq_busy=1 still pulses; the core ignores it.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID && !RVALID && !ARREADY.
  - RDATA is registered from the addressed register at the handshake. RVALID rises the next cycle and holds, with stable RDATA, until RREADY.
- Read/write to the same register in the same cycle: the read returns the pre-write value.
- DONE set and W1C in the same cycle: set wins.
- Read and write channels are fully independent and may complete concurrently.
- ARESET mid-transaction: all valid/ready outputs drop asynchronously and all registers clear. An in-flight master transaction is lost.
- Latency: 2 cycles from both valids to BVALID; 2 cycles from ARVALID to RVALID when the responder is idle.

Decomposition:
- Package adc_acq_regs_pkg holds:
  - register offsets (ADDR_CTRL=0x00 … ADDR_COUNT=0x14);
  - the CTRL/STATUS bit positions;
  - the RESP_OKAY constant;
  - a function applying WSTRB to a 32-bit word.
- Sub-module adc_acq_axil_wr_ch: the write-handshake/BVALID state (IDLE, RESP). The read path stays inline.

Test Plan:
- Sequential writes 0x1, 0x2, 0x3, 0x4 to 0x00–0x0C, then read back:
  - 0x00 returns 0x0 (bit0 self-cleared) and an acq_start pulse of 1 cycle is seen;
  - 0x04/0x08/0x0C return 0x2/0x3/0x4;
  - all BRESP/RRESP = OKAY.
- Write 0xAABBCCDD to 0x0C with WSTRB=4'b0101 over a prior 0x0 -> readback is 0x00BB00DD.
- AWVALID 3 cycles before WVALID, and BREADY held low for 5 cycles:
  - no AWREADY until WVALID;
  - BVALID stays high for the 5 cycles;
  - a second write is not accepted until B completes.
- Pulse acq_done, then read 0x10 -> 0x2. Write 0x2 to 0x10 -> reads 0x0. With acq_done coincident with that W1C -> reads 0x2.
- acq_count=0x1234, acq_busy=1 -> reads of 0x14/0x10 return 0x1234/0x1. Writes to 0x14 leave the value unchanged.
- Assert ARESET while RVALID is pending -> RVALID=0 asynchronously; all registers read 0 after release.
